// File: rtl/divider_unit.sv
// Sequential 8-bit unsigned restoring divider: loads a dividend, then on Run
// shifts and trial-subtracts for eight cycles to leave quotient in B and remainder in A.
module divider_unit (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Load,
    input  logic       Run,
    input  logic [7:0] D,
    output logic [7:0] A,
    output logic [7:0] B,
    output logic       Busy,
    output logic       Done,
    output logic       Div0
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t     state_q;
    logic [7:0] a_q;
    logic [7:0] q_q;
    logic [7:0] m_q;
    logic [2:0] cnt_q;
    logic       div0_q;

    logic [8:0] s_d;
    logic [9:0] t_d;
    logic       ge_d;

    // Trial subtraction on the shifted partial remainder; bit 9 is the borrow.
    assign s_d  = {a_q, q_q[7]};
    assign t_d  = {1'b0, s_d} - {2'b00, m_q};
    assign ge_d = ~t_d[9];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            a_q     <= 8'd0;
            q_q     <= 8'd0;
            m_q     <= 8'd0;
            cnt_q   <= 3'd0;
            div0_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Run) begin
                        m_q     <= D;
                        a_q     <= 8'd0;
                        cnt_q   <= 3'd0;
                        div0_q  <= (D == 8'd0);
                        state_q <= S_COMPUTE;
                    end else if (Load) begin
                        q_q <= D;
                    end
                end
                S_COMPUTE: begin
                    if (ge_d) begin
                        a_q <= t_d[7:0];
                        q_q <= {q_q[6:0], 1'b1};
                    end else begin
                        a_q <= s_d[7:0];
                        q_q <= {q_q[6:0], 1'b0};
                    end
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Wait for Run to drop so one press gives exactly one division.
                    if (!Run) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign A    = a_q;
    assign B    = q_q;
    assign Div0 = div0_q;
    assign Busy = (state_q == S_COMPUTE);
    assign Done = (state_q == S_DONE);

endmodule

// File: tb/tb_divider_unit.sv
// Self-checking bench for divider_unit: directed vector table, mid-operation
// disturbance and reset cases, plus a sweep of all nonzero divisors.
module tb_divider_unit;

    logic       Clk;
    logic       Reset;
    logic       Load;
    logic       Run;
    logic [7:0] D;
    logic [7:0] A;
    logic [7:0] B;
    logic       Busy;
    logic       Done;
    logic       Div0;

    int checks;
    int errors;

    divider_unit dut (
        .Clk  (Clk),
        .Reset(Reset),
        .Load (Load),
        .Run  (Run),
        .D    (D),
        .A    (A),
        .B    (B),
        .Busy (Busy),
        .Done (Done),
        .Div0 (Div0)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0] dvd;
        logic [7:0] dvs;
        logic [7:0] exp_q;
        logic [7:0] exp_a;
        logic       exp_div0;
        int         hold;
        logic       disturb;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [7:0] d);
        @(negedge Clk);
        Load = 1'b1;
        D    = d;
        @(negedge Clk);
        Load = 1'b0;
        chk("load_b", int'(B), int'(d));
    endtask

    // One full division: load, start, count busy cycles, check result, release Run.
    task automatic run_div(input string name, input logic [7:0] dvd, input logic [7:0] dvs,
                           input logic [7:0] exp_q, input logic [7:0] exp_a,
                           input logic exp_div0, input int hold, input logic disturb);
        int  busy_cnt;
        int  edges;
        logic seen;
        do_load(dvd);
        Run      = 1'b1;
        D        = dvs;
        busy_cnt = 0;
        edges    = 0;
        seen     = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge Clk);
            edges++;
            if (Done) begin
                seen = 1'b1;
                break;
            end
            if (Busy) busy_cnt++;
            if (disturb && busy_cnt == 3) begin
                Load = 1'b1;
                D    = 8'h55;
            end else if (disturb && busy_cnt == 4) begin
                Load = 1'b0;
                D    = 8'h01;
            end
        end
        Load = 1'b0;
        chk({name, "_done_seen"}, int'(seen), 1);
        chk({name, "_busy_cycles"}, busy_cnt, 8);
        chk({name, "_latency"}, edges, 9);
        chk({name, "_q"}, int'(B), int'(exp_q));
        chk({name, "_a"}, int'(A), int'(exp_a));
        chk({name, "_div0"}, int'(Div0), int'(exp_div0));
        for (int h = 0; h < hold; h++) begin
            @(negedge Clk);
            chk({name, "_hold_done"}, int'(Done), 1);
            chk({name, "_hold_busy"}, int'(Busy), 0);
            chk({name, "_hold_q"}, int'(B), int'(exp_q));
        end
        Run = 1'b0;
        @(negedge Clk);
        chk({name, "_done_fall"}, int'(Done), 0);
        chk({name, "_idle_busy"}, int'(Busy), 0);
    endtask

    initial begin
        logic [7:0] rd;
        logic [7:0] rq;
        logic [7:0] ra;
        int         busy_cnt;

        checks = 0;
        errors = 0;
        Reset  = 1'b1;
        Load   = 1'b0;
        Run    = 1'b0;
        D      = 8'd0;

        vecs[0] = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 3, 1'b0};
        vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 0, 1'b0};
        vecs[2] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 0, 1'b0};
        vecs[3] = '{8'd0,   8'd3,   8'd0,   8'd0,   1'b0, 0, 1'b0};
        vecs[4] = '{8'd100, 8'd0,   8'hFF,  8'd100, 1'b1, 0, 1'b0};
        vecs[5] = '{8'd100, 8'd10,  8'd10,  8'd0,   1'b0, 0, 1'b0};
        vecs[6] = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 0, 1'b1};
        vecs[7] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 0, 1'b0};
        vecs[8] = '{8'd1,   8'd255, 8'd0,   8'd1,   1'b0, 0, 1'b0};
        vecs[9] = '{8'd128, 8'd2,   8'd64,  8'd0,   1'b0, 1, 1'b0};

        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        chk("rst_a", int'(A), 0);
        chk("rst_b", int'(B), 0);
        chk("rst_busy", int'(Busy), 0);
        chk("rst_done", int'(Done), 0);
        chk("rst_div0", int'(Div0), 0);

        foreach (vecs[i]) begin
            run_div($sformatf("vec%0d", i), vecs[i].dvd, vecs[i].dvs, vecs[i].exp_q,
                    vecs[i].exp_a, vecs[i].exp_div0, vecs[i].hold, vecs[i].disturb);
        end

        // Reset in the 4th COMPUTE cycle discards the partial result.
        do_load(8'd200);
        Run      = 1'b1;
        D        = 8'd7;
        busy_cnt = 0;
        for (int n = 0; n < 20 && busy_cnt < 4; n++) begin
            @(negedge Clk);
            if (Busy) busy_cnt++;
        end
        chk("abort_reached", busy_cnt, 4);
        Reset = 1'b1;
        Run   = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        chk("abort_a", int'(A), 0);
        chk("abort_b", int'(B), 0);
        chk("abort_busy", int'(Busy), 0);
        chk("abort_done", int'(Done), 0);
        @(negedge Clk);
        chk("abort_stays_idle", int'(Busy), 0);
        run_div("after_abort", 8'd50, 8'd6, 8'd8, 8'd2, 1'b0, 0, 1'b0);

        for (int v = 1; v < 256; v++) begin
            rd = 8'($urandom_range(0, 255));
            rq = 8'(int'(rd) / v);
            ra = 8'(int'(rd) % v);
            run_div($sformatf("sweep_%0d_%0d", rd, v), rd, 8'(v), rq, ra, 1'b0, 0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
